conv_fprop1_sdiv_10s_10s_10_seq: RTL

Sequential signed integer divider. It is the arithmetic inverse of the truncating signed multiplier cores used in the conv_fprop1 datapath, and serves the rescale/normalise stage after accumulation. It computes quotient and remainder with C semantics: truncation toward zero, and the remainder takes the sign of the dividend. It uses one restoring iteration per clock, with valid/ready handshakes on both sides.

---
 rtl/conv_fprop1_sdiv_10s_10s_10_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_fprop1_sdiv_10s_10s_10_seq.sv
// Sequential signed divider, one restoring step per clock, C semantics
// (truncate toward zero, remainder follows the dividend's sign).
module conv_fprop1_sdiv_10s_10s_10_seq #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(din0_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // operand context captured at acceptance
  typedef struct packed {
    logic                         s0;
    logic                         s1;
    logic                         dz;
    logic signed [din0_WIDTH-1:0] raw0;
  } opctx_t;

  state_t state, state_nx;
  opctx_t ctx;

  logic [din0_WIDTH-1:0] dvd;   // dividend magnitude, becomes quotient magnitude
  logic [din1_WIDTH-1:0] dsr;
  logic [din1_WIDTH:0]   pr;
  logic [CW-1:0]         cnt;

  logic [din1_WIDTH:0]   pr_sh, pr_sub;
  logic                  qbit;
  logic [din0_WIDTH-1:0] qsgn;
  logic [din1_WIDTH-1:0] rsgn;

  always_comb begin
    pr_sh  = {pr[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
    qbit   = (pr_sh >= {1'b0, dsr});
    pr_sub = pr_sh - {1'b0, dsr};
    qsgn   = (ctx.s0 ^ ctx.s1) ? -dvd : dvd;
    rsgn   = ctx.s0 ? -pr[din1_WIDTH-1:0] : pr[din1_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ctx         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      pr          <= '0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd      <= din0[din0_WIDTH-1] ? -din0 : din0;
          dsr      <= din1[din1_WIDTH-1] ? -din1 : din1;
          ctx.s0   <= din0[din0_WIDTH-1];
          ctx.s1   <= din1[din1_WIDTH-1];
          ctx.dz   <= (din1 == '0);
          ctx.raw0 <= din0;
          pr       <= '0;
          cnt      <= CW'(din0_WIDTH);
        end
        CALC: begin
          pr  <= qbit ? pr_sub : pr_sh;
          dvd <= {dvd[din0_WIDTH-2:0], qbit};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // divide by zero still runs the iterations; the result is overridden here
          quot        <= ctx.dz ? '1 : qsgn[dout_WIDTH-1:0];
          rem         <= ctx.dz ? din1_WIDTH'(ctx.raw0) : rsgn;
          div_by_zero <= ctx.dz;
        end
        default: ;
      endcase
    end
  end
endmodule
